lc3_mem_if: RTL and testbench
=============================

# lc3_mem_if

Memory interface unit of the LC-3 core, sitting directly downstream of the control FSM. It owns MAR and MDR, turns the control strobes (ldMAR, ldMDR, selMDR, memWE) into requests on an external memory port that can stretch accesses with wait states, and decodes the LC-3 memory-mapped keyboard/display registers. While an external access is outstanding it raises memBusy, and the control FSM holds its current state.

## Interface
Parameters:
- KBSR_ADDR, 16'hFE00, keyboard status address
- KBDR_ADDR, 16'hFE02, keyboard data address
- DSR_ADDR, 16'hFE04, display status address
- DDR_ADDR, 16'hFE06, display data address

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- bus  in  16  processor bus value (MAR/MDR load source)
- ldMAR, ldMDR, selMDR, memWE  in  1 each  control strobes
- mdrOut  out  16  MDR contents (tristated onto the bus externally by enaMDR)
- memBusy  out  1  access in progress; control must stall
- mem_req  out  1  external request, held until ack
- mem_we  out  1  request is a write
- mem_addr  out  16  equals MAR
- mem_wdata  out  16  equals MDR
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- kbd_valid  in  1  one-cycle pulse, new key present
- kbd_data  in  8  key code
- dsp_valid  out  1  display character pending
- dsp_data  out  8  DDR[7:0]
- dsp_ready  in  1  display consumed the character (valid & ready = transfer)

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT. Reset → IDLE.
- IDLE:
  - ldMAR: MAR ← bus.
  - ldMDR & !selMDR: MDR ← bus.
  - ldMDR & selMDR, MAR is an I/O address: MDR ← register value at that edge, with no busy cycle.
    - KBSR reads {ready,15'b0}; DSR reads {dsp_idle,15'b0}, where dsp_idle = !dsp_valid.
    - KBDR reads {8'b0,KBDR}.
    - Reading KBDR clears KBSR.ready.
  - ldMDR & selMDR, memory address: assert mem_req with mem_we=0 → RD_WAIT.
  - memWE, I/O address:
    - DDR write: DDR ← MDR[7:0], dsp_valid ← 1.
    - Writes to KBSR, KBDR and DSR are ignored.
    - No busy cycle.
  - memWE, memory address: mem_req=1, mem_we=1 → WR_WAIT.
  - memWE and ldMDR together: memWE has priority; ldMDR is ignored.
- RD_WAIT: on mem_ack, MDR ← mem_rdata → IDLE.
- WR_WAIT: on mem_ack → IDLE.
- While in RD_WAIT/WR_WAIT, all strobes are ignored and MAR/MDR are frozen.
- Keyboard: kbd_valid → KBDR ← kbd_data, KBSR.ready ← 1. A new key overwrites an unread one. If kbd_valid and a KBDR read land in the same cycle, the new key wins and ready stays 1.
- Display: dsp_valid & dsp_ready → dsp_valid ← 0. If a DDR write and a dsp_ready transfer land in the same cycle, the write wins and dsp_valid stays 1.

## Timing
- Reset values: MAR=0, MDR=0, KBDR=0, KBSR.ready=0, DDR=0, dsp_valid=0, mem_req=0, mem_we=0, memBusy=0, state IDLE.
- memBusy and mem_req are registered.
  - Both assert the cycle after the start edge and drop the cycle after the mem_ack edge.
  - memBusy == (state != IDLE).
- Memory latency: start edge + N wait cycles + ack edge. A read whose ack arrives one cycle after the request has MDR valid two edges after the ldMDR edge.
- mem_ack seen in IDLE is ignored.
- rst mid-access: immediate return to IDLE, mem_req drops asynchronously, the access is abandoned, and MDR keeps its reset value.

## Structure
- Add to lc3Pkg:
  - MemIfStates enum (IDLE, RD_WAIT, WR_WAIT).
  - Device address constants, used as the parameter defaults.
- Sub-module lc3_io_regs holds KBSR/KBDR/DSR/DDR:
  - Inputs: decoded address, rd/wr strobes, wdata.
  - Outputs: rdata, isIO.
- The top level contains MAR, MDR and the FSM.

## Test plan
- Reset, then MAR←16'h3000 and a read with ack after 3 cycles, mem_rdata=16'h1234 → memBusy high for exactly 4 cycles, MDR=16'h1234, mem_addr=16'h3000.
- MDR←16'hBEEF, memWE to 16'h4000, ack after 1 cycle → exactly one write request with mem_we=1, mem_wdata=16'hBEEF; memBusy drops the cycle after ack.
- kbd_valid with 8'h41, read KBSR, then KBDR → MDR=16'h8000, then 16'h0041; a second KBSR read gives 16'h0000.
- MDR←16'h0058, memWE to 16'hFE06 → dsp_valid=1, dsp_data=8'h58, DSR reads 0; dsp_ready pulse → dsp_valid=0, DSR reads 16'h8000.
- Same-cycle kbd_valid (8'h42) and KBDR read → MDR gets the old key, KBDR=8'h42, KBSR.ready=1.
- rst asserted during RD_WAIT → mem_req and memBusy drop immediately; a late mem_ack after reset leaves MDR=0.

Source files
------------

// File: rtl/lc3_mem_if_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_if_pkg
// Shared types and constants for the LC-3 memory interface unit:
//   - mem_if_state_e : interface FSM states
//   - *_ADDR_DEF     : memory-mapped device register addresses, used as the
//                      parameter defaults of lc3_mem_if and lc3_io_regs
//   - status_word()  : builds a device status word (flag in bit 15)
// ---------------------------------------------------------------------------
package lc3_mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_if_state_e;

    localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
    localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

    // LC-3 status registers report their single flag in bit 15.
    function automatic logic [15:0] status_word(input logic flag);
        return {flag, 15'b0};
    endfunction

endpackage

// File: rtl/lc3_mem_if_io_regs.sv
// ---------------------------------------------------------------------------
// lc3_io_regs
// Memory-mapped keyboard / display registers of the LC-3.
//   clk, rst          clock, async active-high reset
//   addr              decoded address (MAR)
//   rd, wr            one-cycle read / write strobes, already qualified
//                     with is_io by the caller
//   wdata             write data (only DDR is writable, 8 bits)
//   rdata             register value at addr (combinational)
//   is_io             addr hits one of the four device registers
//   kbd_valid/data    new key pulse and key code
//   dsp_valid/data    pending display character and its code
//   dsp_ready         display accepted the character
// ---------------------------------------------------------------------------
module lc3_io_regs
    import lc3_mem_if_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  wdata,
    output logic [15:0] rdata,
    output logic        is_io,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
);

    logic       sel_kbsr;
    logic       sel_kbdr;
    logic       sel_dsr;
    logic       sel_ddr;
    logic       kbd_ready;
    logic [7:0] kbdr;
    logic [7:0] ddr;

    assign sel_kbsr = (addr == KBSR_ADDR);
    assign sel_kbdr = (addr == KBDR_ADDR);
    assign sel_dsr  = (addr == DSR_ADDR);
    assign sel_ddr  = (addr == DDR_ADDR);
    assign is_io    = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

    assign dsp_data = ddr;

    // DDR reads back as zero; only its low byte exists and it is write-only
    // from the program's point of view.
    always_comb begin
        rdata = 16'h0000;
        if (sel_kbsr)
            rdata = status_word(kbd_ready);
        else if (sel_kbdr)
            rdata = {8'h00, kbdr};
        else if (sel_dsr)
            rdata = status_word(!dsp_valid);
    end

    // A key arriving in the same cycle as a KBDR read wins: the reader gets
    // the old code and the new one stays flagged as unread.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbdr      <= 8'h00;
            kbd_ready <= 1'b0;
        end else if (kbd_valid) begin
            kbdr      <= kbd_data;
            kbd_ready <= 1'b1;
        end else if (rd && sel_kbdr) begin
            kbd_ready <= 1'b0;
        end
    end

    // A DDR write in the same cycle as a display handshake wins: the new
    // character stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ddr       <= 8'h00;
            dsp_valid <= 1'b0;
        end else if (wr && sel_ddr) begin
            ddr       <= wdata;
            dsp_valid <= 1'b1;
        end else if (dsp_valid && dsp_ready) begin
            dsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lc3_mem_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_if
// LC-3 memory interface: owns MAR and MDR, turns the control strobes into
// requests on a wait-state capable external memory port, and routes I/O
// addresses to the keyboard/display registers (no busy cycle for those).
//
//   clk, rst                   clock, async active-high reset
//   bus                        processor bus (MAR/MDR load source)
//   ldMAR, ldMDR, selMDR,      control strobes from the control FSM
//   memWE
//   mdrOut                     MDR contents
//   memBusy                    external access outstanding, control stalls
//   mem_req, mem_we            external request (held until mem_ack)
//   mem_addr, mem_wdata        MAR, MDR
//   mem_rdata, mem_ack         read data and one-cycle completion pulse
//   kbd_valid, kbd_data        keyboard input
//   dsp_valid, dsp_data,       display output handshake
//   dsp_ready
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting strobes; I/O accesses complete here directly
// RD_WAIT | external read outstanding, MDR loads on mem_ack
// WR_WAIT | external write outstanding, done on mem_ack
// ---------------------------------------------------------------------------
module lc3_mem_if
    import lc3_mem_if_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memWE,
    output logic [15:0] mdrOut,
    output logic        memBusy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
);

    mem_if_state_e state;
    logic [15:0]   mar;
    logic [15:0]   mdr;
    logic [15:0]   io_rdata;
    logic          is_io;
    logic          idle;
    logic          io_rd;
    logic          io_wr;

    assign idle      = (state == IDLE);
    // memWE outranks ldMDR, so an I/O read is only issued without memWE.
    assign io_wr     = idle && memWE && is_io;
    assign io_rd     = idle && !memWE && ldMDR && selMDR && is_io;

    assign mdrOut    = mdr;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    lc3_io_regs #(
        .KBSR_ADDR (KBSR_ADDR),
        .KBDR_ADDR (KBDR_ADDR),
        .DSR_ADDR  (DSR_ADDR),
        .DDR_ADDR  (DDR_ADDR)
    ) u_io_regs (
        .clk       (clk),
        .rst       (rst),
        .addr      (mar),
        .rd        (io_rd),
        .wr        (io_wr),
        .wdata     (mdr[7:0]),
        .rdata     (io_rdata),
        .is_io     (is_io),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
    );

    // memBusy mirrors (state != IDLE); it is kept as its own flop so the
    // control FSM sees a clean registered stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mar     <= 16'h0000;
            mdr     <= 16'h0000;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            memBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ldMAR)
                        mar <= bus;
                    if (memWE) begin
                        if (!is_io) begin
                            state   <= WR_WAIT;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                            memBusy <= 1'b1;
                        end
                    end else if (ldMDR) begin
                        if (!selMDR) begin
                            mdr <= bus;
                        end else if (is_io) begin
                            mdr <= io_rdata;
                        end else begin
                            state   <= RD_WAIT;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            memBusy <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        mdr     <= mem_rdata;
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        memBusy <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        memBusy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    memBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_if.sv
module tb_lc3_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        ldMAR, ldMDR, selMDR, memWE;
    logic [15:0] mdrOut;
    logic        memBusy, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [15:0] exp_mdr_q[$];

    always #5 clk = ~clk;

    lc3_mem_if dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ldMAR     (ldMAR),
        .ldMDR     (ldMDR),
        .selMDR    (selMDR),
        .memWE     (memWE),
        .mdrOut    (mdrOut),
        .memBusy   (memBusy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
    );

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic load_mar(input logic [15:0] v);
        bus = v; ldMAR = 1'b1;
        @(negedge clk);
        ldMAR = 1'b0; bus = 16'h0000;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus = v; ldMDR = 1'b1; selMDR = 1'b0;
        @(negedge clk);
        ldMDR = 1'b0; bus = 16'h0000;
    endtask

    task automatic mem_read_strobe();
        ldMDR = 1'b1; selMDR = 1'b1;
        @(negedge clk);
        ldMDR = 1'b0; selMDR = 1'b0;
    endtask

    task automatic mem_write_strobe();
        memWE = 1'b1;
        @(negedge clk);
        memWE = 1'b0;
    endtask

    task automatic kbd_pulse(input logic [7:0] k);
        kbd_valid = 1'b1; kbd_data = k;
        @(negedge clk);
        kbd_valid = 1'b0; kbd_data = 8'h00;
    endtask

    // Plays the memory side of one access: acks after 'waits' wait cycles
    // and reports what it observed.
    task automatic run_access(input int waits, input logic [15:0] rdata,
                              output int busy, output int starts,
                              output int req_mismatch, output req_t first);
        logic prev_req;
        prev_req = 1'b0; busy = 0; starts = 0; req_mismatch = 0; first = '0;
        while (memBusy === 1'b1 && busy < 40) begin
            if (mem_req && !prev_req) begin
                starts++;
                first = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
            end
            if (mem_req !== memBusy) req_mismatch++;
            prev_req = mem_req;
            busy++;
            if (busy == waits + 1) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 16'h0000;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus = 0; ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0;
        mem_rdata = 0; mem_ack = 0; kbd_valid = 0; kbd_data = 0; dsp_ready = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({mdrOut, mem_addr, mem_wdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_regs: mdr=%h mar=%h wdata=%h, want all 0", mdrOut, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({memBusy, mem_req, mem_we, dsp_valid, dsp_data} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b req=%b we=%b dv=%b dd=%h, want 0", memBusy, mem_req, mem_we, dsp_valid, dsp_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_mem_read(input string name, input logic [15:0] addr,
                               input logic [15:0] data, input int waits);
        int busy, starts, mism;
        req_t first, er;
        logic [15:0] em;
        load_mar(addr);
        exp_req_q.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
        exp_mdr_q.push_back(data);
        mem_read_strobe();
        run_access(waits, data, busy, starts, mism, first);
        er = exp_req_q.pop_front();
        em = exp_mdr_q.pop_front();
        n_checks++;
        if (busy !== waits + 1) begin
            n_fail++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy, waits + 1);
        end
        n_checks++;
        if (starts !== 1 || first.we !== er.we || first.addr !== er.addr) begin
            n_fail++;
            $display("FAIL %s_request: starts=%0d we=%b addr=%h, want 1 %b %h", name, starts, first.we, first.addr, er.we, er.addr);
        end
        n_checks++;
        if (mdrOut !== em || mism !== 0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_data: mdr=%h req_mism=%0d req=%b, want %h 0 0", name, mdrOut, mism, mem_req, em);
        end
    endtask

    task automatic test_mem_read();
        do_mem_read("read3", 16'h3000, 16'h1234, 3);
        n_checks++;
        if (mem_addr !== 16'h3000) begin
            n_fail++; $display("FAIL read3_mar: got %h want 3000", mem_addr);
        end
    endtask

    task automatic test_mem_write();
        int busy, starts, mism;
        req_t first, er;
        load_mdr(16'hBEEF);
        load_mar(16'h4000);
        exp_req_q.push_back('{we: 1'b1, addr: 16'h4000, wdata: 16'hBEEF});
        mem_write_strobe();
        run_access(1, 16'h0000, busy, starts, mism, first);
        er = exp_req_q.pop_front();
        n_checks++;
        if (starts !== 1 || first !== er) begin
            n_fail++;
            $display("FAIL write_request: starts=%0d we=%b addr=%h wdata=%h, want 1 %b %h %h",
                     starts, first.we, first.addr, first.wdata, er.we, er.addr, er.wdata);
        end
        n_checks++;
        if (busy !== 2 || memBusy !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mism !== 0) begin
            n_fail++;
            $display("FAIL write_busy: cycles=%0d busy=%b req=%b we=%b, want 2 0 0 0", busy, memBusy, mem_req, mem_we);
        end
        n_checks++;
        if (mdrOut !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_mdr_kept: got %h want beef", mdrOut);
        end
    endtask

    task automatic io_read_check(input string name, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] em;
        load_mar(addr);
        exp_mdr_q.push_back(exp);
        mem_read_strobe();
        em = exp_mdr_q.pop_front();
        n_checks++;
        if (mdrOut !== em || memBusy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: mdr=%h busy=%b req=%b, want %h 0 0", name, mdrOut, memBusy, mem_req, em);
        end
    endtask

    task automatic test_keyboard();
        kbd_pulse(8'h41);
        io_read_check("kbsr_ready", 16'hFE00, 16'h8000);
        io_read_check("kbdr_key",   16'hFE02, 16'h0041);
        io_read_check("kbsr_clear", 16'hFE00, 16'h0000);
    endtask

    task automatic test_display();
        load_mdr(16'h0058);
        load_mar(16'hFE06);
        mem_write_strobe();
        n_checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h58 || memBusy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ddr_write: dv=%b dd=%h busy=%b req=%b, want 1 58 0 0", dsp_valid, dsp_data, memBusy, mem_req);
        end
        io_read_check("dsr_busy", 16'hFE04, 16'h0000);
        dsp_ready = 1'b1; @(negedge clk); dsp_ready = 1'b0;
        n_checks++;
        if (dsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL dsp_handshake: dv=%b want 0", dsp_valid);
        end
        io_read_check("dsr_idle", 16'hFE04, 16'h8000);
        // write and handshake in the same cycle: write wins
        load_mdr(16'h0061);
        load_mar(16'hFE06);
        mem_write_strobe();
        load_mdr(16'h0062);
        memWE = 1'b1; dsp_ready = 1'b1;
        @(negedge clk);
        memWE = 1'b0; dsp_ready = 1'b0;
        n_checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h62) begin
            n_fail++; $display("FAIL ddr_write_vs_ready: dv=%b dd=%h, want 1 62", dsp_valid, dsp_data);
        end
        dsp_ready = 1'b1; @(negedge clk); dsp_ready = 1'b0;
    endtask

    task automatic test_kbd_collision();
        logic [15:0] em;
        kbd_pulse(8'h41);
        load_mar(16'hFE02);
        exp_mdr_q.push_back(16'h0041);
        ldMDR = 1'b1; selMDR = 1'b1; kbd_valid = 1'b1; kbd_data = 8'h42;
        @(negedge clk);
        ldMDR = 1'b0; selMDR = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00;
        em = exp_mdr_q.pop_front();
        n_checks++;
        if (mdrOut !== em) begin
            n_fail++; $display("FAIL kbd_collision_old_key: got %h want %h", mdrOut, em);
        end
        io_read_check("kbd_collision_ready", 16'hFE00, 16'h8000);
        io_read_check("kbd_collision_new",   16'hFE02, 16'h0042);
    endtask

    task automatic test_priority();
        load_mdr(16'h1111);
        load_mar(16'hFE00);
        // memWE outranks ldMDR; the KBSR write itself is dropped
        memWE = 1'b1; ldMDR = 1'b1; selMDR = 1'b0; bus = 16'hABCD;
        @(negedge clk);
        memWE = 1'b0; ldMDR = 1'b0; bus = 16'h0000;
        n_checks++;
        if (mdrOut !== 16'h1111 || memBusy !== 1'b0) begin
            n_fail++; $display("FAIL we_over_ldmdr: mdr=%h busy=%b, want 1111 0", mdrOut, memBusy);
        end
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        n_checks++;
        if (mdrOut !== 16'h1111 || memBusy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: mdr=%h busy=%b req=%b, want 1111 0 0", mdrOut, memBusy, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            logic [15:0] a, d;
            int w;
            a = 16'($urandom_range(16'hFDFF, 0));
            d = 16'($urandom);
            w = (i == 0) ? 0 : int'($urandom_range(4, 0));
            do_mem_read($sformatf("b2b%0d", i), a, d, w);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] em;
        load_mar(16'h3000);
        mem_read_strobe();
        @(negedge clk);
        n_checks++;
        if (memBusy !== 1'b1 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: busy=%b req=%b, want 1 1", memBusy, mem_req);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || memBusy !== 1'b0 || mdrOut !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_async: req=%b busy=%b mdr=%h, want 0 0 0", mem_req, memBusy, mdrOut);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_mdr_q.push_back(16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        em = exp_mdr_q.pop_front();
        n_checks++;
        if (mdrOut !== em || memBusy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_late_ack: mdr=%h busy=%b req=%b mar=%h, want %h 0 0 0", mdrOut, memBusy, mem_req, mem_addr, em);
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_mem_write();
        test_keyboard();
        test_display();
        test_kbd_collision();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
